// File: rtl/sr_flag_if.sv
// Request/grant and latch-bank signals shared by sr_flag_ctrl and its two requesters.
interface sr_flag_if #(
    parameter int N_FLAGS = 8,
    parameter int IDX_W   = 3
);
    logic               req0;
    logic               req1;
    logic               op0;
    logic               op1;
    logic [IDX_W-1:0]   idx0;
    logic [IDX_W-1:0]   idx1;
    logic               clr_err;
    logic               gnt0;
    logic               gnt1;
    logic [N_FLAGS-1:0] s_out;
    logic [N_FLAGS-1:0] r_out;
    logic [N_FLAGS-1:0] q;
    logic               busy;
    logic [1:0]         err;

    modport master (
        output req0, req1, op0, op1, idx0, idx1, clr_err,
        input  gnt0, gnt1, s_out, r_out, q, busy, err
    );

    modport slave (
        input  req0, req1, op0, op1, idx0, idx1, clr_err,
        output gnt0, gnt1, s_out, r_out, q, busy, err
    );
endinterface

// File: rtl/sr_flag_ctrl.sv
// Two-requester round-robin sequencer that drives one-cycle set/reset pulses
// into an external SR-latch bank, with a guard cycle between operations,
// a registered flag mirror and sticky protocol-error bits.
module sr_flag_ctrl #(
    parameter int N_FLAGS = 8,
    parameter int IDX_W   = 3
) (
    input  logic      clk,
    input  logic      rst,
    sr_flag_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, GUARD} state_t;

    localparam int unsigned          NF_I = N_FLAGS;
    localparam logic [IDX_W:0]       NF   = NF_I[IDX_W:0];
    localparam logic [N_FLAGS-1:0]   ONE  = {{(N_FLAGS-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic               last_q, last_d;
    logic               gnt0_q, gnt0_d;
    logic               gnt1_q, gnt1_d;
    logic [N_FLAGS-1:0] s_q, s_d;
    logic [N_FLAGS-1:0] r_q, r_d;
    logic [N_FLAGS-1:0] flags_q, flags_d;
    logic               busy_q, busy_d;
    logic [1:0]         err_q, err_d;

    logic               win1;
    logic               win_op;
    logic [IDX_W-1:0]   win_idx;
    logic [N_FLAGS-1:0] win_oh;

    // Arbitration, next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        s_d     = '0;
        r_d     = '0;
        flags_d = flags_q;
        err_d   = bus.clr_err ? 2'b00 : err_q;
        // On a tie the requester that did not win last time goes first.
        win1    = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
        win_op  = win1 ? bus.op1 : bus.op0;
        win_idx = win1 ? bus.idx1 : bus.idx0;
        win_oh  = ONE << win_idx;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d = DRIVE;
                    last_d  = win1;
                    gnt0_d  = ~win1;
                    gnt1_d  = win1;
                    if (bus.req0 && bus.req1 && (bus.idx0 == bus.idx1) && (bus.op0 != bus.op1))
                        err_d[0] = 1'b1;
                    if ({1'b0, win_idx} < NF) begin
                        if (win_op) begin
                            s_d     = win_oh;
                            flags_d = flags_q | win_oh;
                        end else begin
                            r_d     = win_oh;
                            flags_d = flags_q & ~win_oh;
                        end
                    end else begin
                        // Out-of-range index: handshake completes, no latch is touched.
                        err_d[1] = 1'b1;
                    end
                end
            end
            DRIVE:   state_d = GUARD;
            GUARD:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Output, pointer, mirror and error registers; last starts at 1 so req0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q  <= 1'b1;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            s_q     <= '0;
            r_q     <= '0;
            flags_q <= '0;
            busy_q  <= 1'b0;
            err_q   <= 2'b00;
        end else begin
            last_q  <= last_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            s_q     <= s_d;
            r_q     <= r_d;
            flags_q <= flags_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign bus.gnt0  = gnt0_q;
    assign bus.gnt1  = gnt1_q;
    assign bus.s_out = s_q;
    assign bus.r_out = r_q;
    assign bus.q     = flags_q;
    assign bus.busy  = busy_q;
    assign bus.err   = err_q;
endmodule
